// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin burst read arbiter sharing one synchronous ROM between two requesters
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   req0/addr0/len0            requester 0 request, start address, burst length minus 1
//   ack0/rvalid0/rdata0/done0  requester 0 accept pulse, returned word strobe/data, last-word pulse
//   req1 ... done1             same for requester 1
//   rom_read/rom_addr          ROM read enable and address (driven only by this block)
//   rom_data                   ROM data, valid RD_LAT cycles after the address
//
// Optional feature macro: ROM_ARB_FIXED_PRIO_EN
//   defined   -> requester 0 always wins ties
//   undefined -> round-robin tie break using the last granted requester
module rom_read_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] len0,
  output logic          ack0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          done0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len1,
  output logic          ack1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          done1,
  output logic          rom_read,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t        state, next_state;
  logic          owner;
  logic          grant_vld;
  logic          grant_id;
  logic [AW-1:0] cnt;
  logic [AW-1:0] k;
  logic          last_addr;
  // Bit i is set during the cycle i+1 after an address cycle; the top bit
  // marks the cycle in which the ROM word for that address is on rom_data.
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic              capture;
`ifndef ROM_ARB_FIXED_PRIO_EN
  logic          last_owner;
`endif

  assign last_addr = rom_read && (k == cnt);
  assign capture   = vld_pipe[RD_LAT-1];

  // Tie break: only consulted when both requests are high.
  always_comb begin
    grant_id = 1'b0;
`ifdef ROM_ARB_FIXED_PRIO_EN
    grant_id = req1 & ~req0;
`else
    if (req0 && req1) grant_id = ~last_owner;
    else              grant_id = req1;
`endif
  end

  always_comb begin
    next_state = state;
    grant_vld  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_vld  = 1'b1;
          next_state = BURST;
        end
      end
      BURST: begin
        if (k == cnt) next_state = DRAIN;
      end
      DRAIN: begin
        // done is registered, so the cycle it is visible is the last one here.
        if (done0 || done1) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b0;
      cnt       <= '0;
      k         <= '0;
      rom_read  <= 1'b0;
      rom_addr  <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      done0     <= 1'b0;
      done1     <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_owner <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;

      if (grant_vld) begin
        owner    <= grant_id;
        cnt      <= grant_id ? len1 : len0;
        rom_addr <= grant_id ? addr1 : addr0;
        k        <= '0;
        rom_read <= 1'b1;
        ack0     <= ~grant_id;
        ack1     <= grant_id;
`ifndef ROM_ARB_FIXED_PRIO_EN
        last_owner <= grant_id;
`endif
      end else if (state == BURST) begin
        if (k == cnt) begin
          rom_read <= 1'b0;
        end else begin
          k        <= k + AW'(1);
          rom_addr <= rom_addr + AW'(1);
        end
      end

      vld_pipe  <= (vld_pipe << 1) | RD_LAT'(rom_read);
      last_pipe <= (last_pipe << 1) | RD_LAT'(last_addr);

      // Only the current owner's strobes move; the other side's data holds.
      rvalid0 <= capture && !owner;
      rvalid1 <= capture && owner;
      done0   <= capture && !owner && last_pipe[RD_LAT-1];
      done1   <= capture && owner && last_pipe[RD_LAT-1];
      if (capture && !owner) rdata0 <= rom_data;
      if (capture && owner)  rdata1 <= rom_data;
    end
  end

endmodule
